// File: rtl/fp_display_scheduler.sv
// Round-robin scheduler sharing one float-to-7seg convertor; FP_SCHED_DEDUP_EN skips reconverting the displayed value.
// Latency: done RESET_CYCLES+CONV_CYCLES+1 after accept; backpressure: one-hot req_ready only in IDLE, held off through DWELL.
module fp_display_scheduler #(
   parameter int NUM_REQ       = 4,
   parameter int DISPLAY_WIDTH = 12,
   parameter int RESET_CYCLES  = 2,
   parameter int CONV_CYCLES   = 1000,
   parameter int DWELL_CYCLES  = 2000,
   localparam int IDX_W        = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ-1:0][31:0]      req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [31:0]                   conv_floating_point,
   output logic                          conv_reset,
   input  logic [DISPLAY_WIDTH-1:0][6:0] conv_segments,
   output logic [DISPLAY_WIDTH-1:0][6:0] display_segments,
   output logic [IDX_W-1:0]              display_owner,
   output logic                          busy,
   output logic                          done
);

   localparam int MAX_A   = (CONV_CYCLES > DWELL_CYCLES) ? CONV_CYCLES : DWELL_CYCLES;
   localparam int MAX_CYC = (MAX_A > RESET_CYCLES) ? MAX_A : RESET_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   typedef enum logic [1:0] {IDLE, CONV_RST, CONVERT, DWELL} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [IDX_W-1:0] rr_ptr;
   logic [IDX_W-1:0] pend_owner;
   logic [IDX_W-1:0] grant;
   logic             grant_vld;
   logic             accept;
   logic             dedup_hit;

   // Lowest offset from rr_ptr wins, so scan from the far end and let nearer hits overwrite.
   always_comb begin
      grant_vld = 1'b0;
      grant     = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
            grant_vld = 1'b1;
            grant     = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
         end
      end
   end

   assign accept = (state == IDLE) && grant_vld;

`ifdef FP_SCHED_DEDUP_EN
   logic [31:0] disp_val;
   logic        cap_vld;

   assign dedup_hit = cap_vld && (req_data[grant] == disp_val);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         disp_val <= '0;
         cap_vld  <= 1'b0;
      end else if (state == CONVERT && cnt == '0) begin
         disp_val <= conv_floating_point;
         cap_vld  <= 1'b1;
      end
   end
`else
   assign dedup_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (grant_vld) state_nxt = dedup_hit ? DWELL : CONV_RST;
         CONV_RST: if (cnt == '0) state_nxt = CONVERT;
         CONVERT:  if (cnt == '0) state_nxt = DWELL;
         DWELL:    if (cnt == '0) state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   // conv_reset and req_ready follow the async reset directly so they are correct mid-cycle.
   always_comb begin
      req_ready  = '0;
      if (reset && accept) req_ready[grant] = 1'b1;
      conv_reset = !reset || (state == CONV_RST);
      busy       = (state != IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt                 <= '0;
         rr_ptr              <= '0;
         pend_owner          <= '0;
         conv_floating_point <= '0;
         display_segments    <= '0;
         display_owner       <= '0;
         done                <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  conv_floating_point <= req_data[grant];
                  pend_owner          <= grant;
                  rr_ptr              <= (int'(grant) == NUM_REQ - 1) ? '0 : grant + IDX_W'(1);
                  if (dedup_hit) begin
                     display_owner <= grant;
                     done          <= 1'b1;
                     cnt           <= CNT_W'(DWELL_CYCLES);
                  end else begin
                     cnt <= CNT_W'(RESET_CYCLES - 1);
                  end
               end
            end
            CONV_RST: begin
               if (cnt == '0) cnt <= CNT_W'(CONV_CYCLES - 1);
               else           cnt <= cnt - CNT_W'(1);
            end
            CONVERT: begin
               if (cnt == '0) begin
                  display_segments <= conv_segments;
                  display_owner    <= pend_owner;
                  done             <= 1'b1;
                  cnt              <= CNT_W'(DWELL_CYCLES);
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            DWELL: begin
               if (cnt != '0) cnt <= cnt - CNT_W'(1);
            end
            default: cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_display_scheduler.sv
// Scoreboard bench for fp_display_scheduler with a behavioural convertor model; second instance covers zero dwell.
module tb_fp_display_scheduler;

   localparam int N   = 4;
   localparam int DW  = 12;
   localparam int RC  = 2;
   localparam int CC  = 8;
   localparam int DC  = 4;
   localparam int LAT = RC + CC + 1;
`ifdef FP_SCHED_DEDUP_EN
   localparam bit DEDUP = 1'b1;
`else
   localparam bit DEDUP = 1'b0;
`endif

   typedef struct {
      logic [31:0] data;
      int          owner;
      int          acc_cyc;
      int          lat;
   } sb_t;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [N-1:0]         req_valid;
   logic [N-1:0][31:0]   req_data;
   logic [N-1:0]         req_ready;
   logic [31:0]          conv_fp;
   logic                 conv_reset;
   logic [DW-1:0][6:0]   conv_segments;
   logic [DW-1:0][6:0]   display_segments;
   logic [1:0]           display_owner;
   logic                 busy;
   logic                 done;

   logic [N-1:0]         z_valid;
   logic [N-1:0][31:0]   z_data;
   logic [N-1:0]         z_ready;
   logic [31:0]          z_fp;
   logic                 z_conv_reset;
   logic [DW-1:0][6:0]   z_conv_segments;
   logic [DW-1:0][6:0]   z_disp;
   logic [1:0]           z_owner;
   logic                 z_busy;
   logic                 z_done;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          cyc = 0;
   int          rr_m = 0;
   bit          cap_m = 1'b0;
   logic [31:0] last_cap = '0;
   int          last_acc = -1;
   bit          chk_gap = 1'b0;
   int          rst_run = 0;
   sb_t         sb_q[$];
   logic [31:0] req_q[N][$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   function automatic logic [DW*7-1:0] seg_of(input logic [31:0] v);
      return {v[19:0] ^ 20'hA5A5A, v, ~v};
   endfunction

   // Convertor stand-in: blank while held in reset, a fixed pattern per value otherwise.
   assign conv_segments   = conv_reset ? '0 : seg_of(conv_fp);
   assign z_conv_segments = z_conv_reset ? '0 : seg_of(z_fp);

   fp_display_scheduler #(.NUM_REQ(N), .DISPLAY_WIDTH(DW), .RESET_CYCLES(RC),
                          .CONV_CYCLES(CC), .DWELL_CYCLES(DC)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .conv_floating_point(conv_fp), .conv_reset(conv_reset),
      .conv_segments(conv_segments), .display_segments(display_segments),
      .display_owner(display_owner), .busy(busy), .done(done));

   fp_display_scheduler #(.NUM_REQ(N), .DISPLAY_WIDTH(DW), .RESET_CYCLES(RC),
                          .CONV_CYCLES(CC), .DWELL_CYCLES(0)) dut_z (
      .clk(clk), .reset(reset), .req_valid(z_valid), .req_data(z_data),
      .req_ready(z_ready), .conv_floating_point(z_fp), .conv_reset(z_conv_reset),
      .conv_segments(z_conv_segments), .display_segments(z_disp),
      .display_owner(z_owner), .busy(z_busy), .done(z_done));

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int exp_grant();
      for (int k = 0; k < N; k++)
         if (req_valid[(rr_m + k) % N]) return (rr_m + k) % N;
      return -1;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
         req_valid[i] = (req_q[i].size() != 0);
         req_data[i]  = req_valid[i] ? req_q[i][0] : 32'h0;
      end
   endtask

   task automatic wait_idle(input int max_cyc);
      int k;
      k = 0;
      do begin
         step();
         k++;
      end while (k < max_cyc && (sb_q.size() != 0 || busy ||
                 req_q[0].size() + req_q[1].size() + req_q[2].size() + req_q[3].size() != 0));
      if (k >= max_cyc) chk("idle_timeout", 1, 0);
   endtask

   task automatic model_reset();
      sb_q.delete();
      rr_m     = 0;
      cap_m    = 1'b0;
      rst_run  = 0;
      last_acc = -1;
   endtask

   task automatic pulse_reset();
      reset = 1'b0;
      model_reset();
      step();
      step();
      reset = 1'b1;
   endtask

   always @(negedge clk) begin
      int  g;
      sb_t e;
      if (reset) begin
         if (conv_reset) rst_run++;
         else if (rst_run != 0) begin
            chk("conv_rst_len", rst_run, RC);
            rst_run = 0;
         end
      end
      if (req_ready != '0) begin
         g = exp_grant();
         chk("grant", req_ready, (g < 0) ? 0 : (1 << g));
         if (chk_gap && last_acc >= 0) chk("acc_gap", cyc - last_acc, LAT + 1 + DC);
         last_acc = cyc;
         if (g >= 0 && req_q[g].size() != 0) begin
            e.data    = req_q[g][0];
            e.owner   = g;
            e.acc_cyc = cyc;
            e.lat     = (DEDUP && cap_m && e.data == last_cap) ? 1 : LAT;
            sb_q.push_back(e);
            rr_m = (g + 1) % N;
            void'(req_q[g].pop_front());
         end
      end
      if (done) begin
         if (sb_q.size() == 0) chk("done_unexpected", 1, 0);
         else begin
            e = sb_q.pop_front();
            chk("display", display_segments, seg_of(e.data));
            chk("owner", display_owner, e.owner);
            chk("latency", cyc - e.acc_cyc, e.lat);
            last_cap = e.data;
            cap_m    = 1'b1;
         end
      end
   end

   initial begin
      int acc[$];
      int dn[$];
      int k;
      reset     = 1'b1;
      req_valid = '0;
      req_data  = '0;
      z_valid   = '0;
      z_data    = '0;
      #2 reset  = 1'b0;
      repeat (3) @(posedge clk);
      #1 req_valid = '1;
      @(negedge clk);
      chk("rst_display", display_segments, 0);
      chk("rst_owner", display_owner, 0);
      chk("rst_conv_fp", conv_fp, 0);
      chk("rst_conv_reset", conv_reset, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", req_ready, 0);
      req_valid = '0;
      @(posedge clk);
      #1 reset = 1'b1;

      // Single request, 1.5
      req_q[0].push_back(32'h3FC00000);
      wait_idle(100);

      // Three requesters held valid from reset release
      pulse_reset();
      chk_gap = 1'b1;
      for (int r = 0; r < 2; r++) begin
         req_q[0].push_back(32'h40600000);
         req_q[1].push_back(32'h41499999);
         req_q[2].push_back(32'h43B6A000);
      end
      wait_idle(300);
      chk_gap = 1'b0;

      // Move rr_ptr to 1, then lone +Inf on requester 3
      req_q[0].push_back(32'h3F800000);
      wait_idle(100);
      req_q[3].push_back(32'h7F800000);
      wait_idle(100);

      // Abort mid-CONVERT with req1 pending
      req_q[0].push_back(32'h40490FDB);
      k = 0;
      while (k < 50 && sb_q.size() == 0) begin
         step();
         k++;
      end
      if (k >= 50) chk("abort_acc_timeout", 1, 0);
      req_q[1].push_back(32'h41200000);
      repeat (RC + 4) step();
      reset = 1'b0;
      model_reset();
      #1;
      chk("abort_display", display_segments, 0);
      chk("abort_busy", busy, 0);
      chk("abort_conv_reset", conv_reset, 1);
      chk("abort_ready", req_ready, 0);
      step();
      step();
      reset = 1'b1;
      @(negedge clk);
      chk("first_idle_acc", req_ready, 4'b0010);
      wait_idle(100);

      // Same value again from a different requester
      req_q[0].push_back(32'h3FC00000);
      wait_idle(100);
      req_q[1].push_back(32'h3FC00000);
      wait_idle(100);

      // Zero dwell: back-to-back conversions of 0.0
      z_valid = 4'b0001;
      k = 0;
      while (k < 200 && acc.size() < 4) begin
         @(negedge clk);
         if (z_ready[0]) acc.push_back(cyc);
         if (z_done) begin
            dn.push_back(cyc);
            chk("z_display", z_disp, seg_of(32'h0));
         end
         k++;
      end
      if (acc.size() < 4 || dn.size() < 3) chk("z_timeout", 1, 0);
      else begin
         for (int i = 0; i < 3; i++) begin
            chk("z_b2b", acc[i+1], dn[i] + 1);
            chk("z_latency", dn[i] - acc[i], (DEDUP && i > 0) ? 1 : LAT);
         end
      end
      #1 z_valid = '0;

      chk("sb_empty", sb_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
